// File: rtl/prog_loader.sv
// Boot-time program loader: parses SYNC, LEN, payload, CSUM frames from a
// valid/ready byte stream, writes the payload to memory and releases cpu_reset on a good checksum.
module prog_loader #(
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_reset,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t     state, state_n;
   logic [8:0] count, count_n;
   logic [7:0] sum, sum_n;
   logic [7:0] addr, addr_n;
   logic       mem_we_n;
   logic [7:0] mem_addr_n, mem_wdata_n;
   logic       accept;

   always_comb begin
      accept      = rx_valid && rx_ready;
      state_n     = state;
      count_n     = count;
      sum_n       = sum;
      addr_n      = addr;
      mem_we_n    = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      if (accept) begin
         case (state)
            S_IDLE, S_ERR: begin
               if (rx_data == SYNC_BYTE) state_n = S_LEN;
            end
            S_LEN: begin
               // LEN=0 encodes a full 256-byte payload
               count_n = {rx_data == 8'h00, rx_data};
               sum_n   = '0;
               addr_n  = BASE_ADDR;
               state_n = S_DATA;
            end
            S_DATA: begin
               mem_we_n    = 1'b1;
               mem_addr_n  = addr;
               mem_wdata_n = rx_data;
               sum_n       = sum + rx_data;
               addr_n      = addr + 8'd1;
               count_n     = count - 9'd1;
               if (count == 9'd1) state_n = S_CSUM;
            end
            S_CSUM: begin
               state_n = (rx_data == sum) ? S_DONE : S_ERR;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= '0;
         sum       <= '0;
         addr      <= BASE_ADDR;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         rx_ready  <= 1'b0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         sum       <= sum_n;
         addr      <= addr_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         // status flags are registered from the next state so they align with it
         rx_ready  <= (state_n != S_DONE);
         cpu_reset <= (state_n != S_DONE);
         done      <= (state_n == S_DONE);
         err       <= (state_n == S_ERR);
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand-written timing
// sequences and random frames against a stream-level reference parser.
module tb_prog_loader;

   localparam logic [7:0] SYNC = 8'hA5;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;

   logic       rdy0, we0, cr0, done0, err0;
   logic [7:0] addr0, wd0;
   logic       rdy1, we1, cr1, done1, err1;
   logic [7:0] addr1, wd1;

   always #5 clock = ~clock;

   prog_loader #(.BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5)) dut0 (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
      .cpu_reset(cr0), .done(done0), .err(err0)
   );

   prog_loader #(.BASE_ADDR(8'hF0), .SYNC_BYTE(8'hA5)) dut1 (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
      .cpu_reset(cr1), .done(done1), .err(err1)
   );

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   typedef wr_t wq_t[$];

   typedef struct {
      int          n;
      logic [95:0] bytes;
      logic        xd;
      logic        xe;
      int          xw;
   } vec_t;

   wq_t cap0, cap1;
   int  total = 0;
   int  bad   = 0;

   always @(negedge clock) begin
      if (we0) cap0.push_back({addr0, wd0});
      if (we1) cap1.push_back({addr1, wd1});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      repeat (2) @(negedge clock);
      cap0 = {};
      cap1 = {};
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Present one byte and return at the negedge after it is accepted.
   task automatic send(input logic [7:0] b, input bit gaps);
      int k;
      if (gaps && $urandom_range(0, 2) == 0) begin
         rx_valid = 1'b0;
         @(negedge clock);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      k = 0;
      while (!rdy0 && k < 50) begin
         @(negedge clock);
         k++;
      end
      if (k >= 50) begin
         chk("rx_ready timeout", 32'(rdy0), 32'd1);
         rx_valid = 1'b0;
      end else begin
         @(negedge clock);
      end
   endtask

   // Reference parser over the whole byte stream: returns expected writes,
   // how many bytes the loader will accept, and the final done/err flags.
   task automatic model(input bq_t s, input logic [7:0] base, output wq_t w,
                        output int used, output logic m_done, output logic m_err);
      int i, n, len, sum;
      w = {};
      i = 0;
      n = s.size();
      m_done = 1'b0;
      m_err  = 1'b0;
      while (i < n && !m_done) begin
         if (s[i] != SYNC) begin
            i++;
            continue;
         end
         i++;
         m_err = 1'b0;
         if (i >= n) break;
         len = (s[i] == 8'h00) ? 256 : int'(s[i]);
         i++;
         sum = 0;
         for (int j = 0; j < len && i < n; j++) begin
            w.push_back({base + 8'(j), s[i]});
            sum += int'(s[i]);
            i++;
         end
         if (i >= n) break;
         if (s[i] == 8'(sum)) m_done = 1'b1;
         else m_err = 1'b1;
         i++;
      end
      used = i;
   endtask

   task automatic cmp_writes(input string tag, input wq_t got, input wq_t exp);
      int m;
      chk({tag, " write count"}, 32'(got.size()), 32'(exp.size()));
      m = (got.size() < exp.size()) ? got.size() : exp.size();
      for (int i = 0; i < m; i++)
         chk({tag, " write"}, 32'(got[i]), 32'(exp[i]));
   endtask

   task automatic run_stream(input string tag, input bq_t s, input bit gaps);
      wq_t  e0, e1;
      int   used0, used1;
      logic md, me, md1, me1;
      model(s, 8'h00, e0, used0, md, me);
      model(s, 8'hF0, e1, used1, md1, me1);
      do_reset();
      for (int i = 0; i < used0; i++) send(s[i], gaps);
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
      cmp_writes({tag, " dut0"}, cap0, e0);
      cmp_writes({tag, " dut1"}, cap1, e1);
      chk({tag, " done0"}, 32'(done0), 32'(md));
      chk({tag, " err0"}, 32'(err0), 32'(me));
      chk({tag, " cpu_reset0"}, 32'(cr0), 32'(!md));
      chk({tag, " rx_ready0"}, 32'(rdy0), 32'(!md));
      chk({tag, " done1"}, 32'(done1), 32'(md1));
      chk({tag, " err1"}, 32'(err1), 32'(me1));
      chk({tag, " cpu_reset1"}, 32'(cr1), 32'(!md1));
   endtask

   function automatic vec_t mk(input int n, input logic [95:0] v, input logic xd,
                               input logic xe, input int xw);
      vec_t r;
      r.n     = n;
      r.bytes = v << (8 * (12 - n));
      r.xd    = xd;
      r.xe    = xe;
      r.xw    = xw;
      return r;
   endfunction

   initial begin
      vec_t tbl[8];
      bq_t  s;
      logic [7:0] csum;
      int   len;

      tbl[0] = mk(6, 96'hA5_03_11_22_33_66, 1, 0, 3);
      tbl[1] = mk(5, 96'hA5_02_01_02_04, 0, 1, 2);
      tbl[2] = mk(9, 96'hA5_02_01_02_04_A5_01_7F_7F, 1, 0, 3);
      tbl[3] = mk(7, 96'h00_FF_5A_A5_01_A5_A5, 1, 0, 1);
      tbl[4] = mk(9, 96'hA5_01_10_11_33_A5_01_10_10, 1, 0, 2);
      tbl[5] = mk(5, 96'hA5_02_FF_02_01, 1, 0, 2);
      tbl[6] = mk(3, 96'hA5_03_01, 0, 0, 1);
      tbl[7] = mk(8, 96'hA5_01_10_11_33_44_00_A5, 0, 0, 1);

      // reset values
      reset = 1'b1;
      rx_valid = 1'b0;
      rx_data = '0;
      repeat (2) @(negedge clock);
      chk("reset rx_ready", 32'(rdy0), 32'd0);
      chk("reset mem_we", 32'(we0), 32'd0);
      chk("reset mem_addr", 32'(addr0), 32'h00);
      chk("reset mem_addr base F0", 32'(addr1), 32'hF0);
      chk("reset mem_wdata", 32'(wd0), 32'h00);
      chk("reset cpu_reset", 32'(cr0), 32'd1);
      chk("reset done", 32'(done0), 32'd0);
      chk("reset err", 32'(err0), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("rx_ready after reset", 32'(rdy0), 32'd1);

      for (int t = 0; t < 8; t++) begin
         s = {};
         for (int i = 0; i < tbl[t].n; i++) s.push_back(tbl[t].bytes[95 - 8 * i -: 8]);
         run_stream($sformatf("vec%0d", t), s, 1'b0);
         chk($sformatf("vec%0d exp done", t), 32'(done0), 32'(tbl[t].xd));
         chk($sformatf("vec%0d exp err", t), 32'(err0), 32'(tbl[t].xe));
         chk($sformatf("vec%0d exp writes", t), 32'(cap0.size()), 32'(tbl[t].xw));
      end

      // write latency and completion timing on the good frame
      do_reset();
      send(8'hA5, 1'b0);
      chk("seq sync no write", 32'(we0), 32'd0);
      send(8'h03, 1'b0);
      send(8'h11, 1'b0);
      chk("seq w0", 32'({we0, addr0, wd0}), 32'({1'b1, 8'h00, 8'h11}));
      send(8'h22, 1'b0);
      chk("seq w1", 32'({we0, addr0, wd0}), 32'({1'b1, 8'h01, 8'h22}));
      send(8'h33, 1'b0);
      chk("seq w2", 32'({we0, addr0, wd0}), 32'({1'b1, 8'h02, 8'h33}));
      send(8'h66, 1'b0);
      chk("seq done", 32'({done0, cr0, rdy0, we0}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
      rx_data = 8'hA5;
      repeat (3) @(negedge clock);
      rx_valid = 1'b0;
      chk("seq done sticky", 32'({done0, cr0, rdy0, we0}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
      chk("seq total writes", 32'(cap0.size()), 32'd3);

      // stalls during DATA
      do_reset();
      send(8'hA5, 1'b0);
      send(8'h04, 1'b0);
      for (int i = 0; i < 4; i++) begin
         send(8'h20 + 8'(i), 1'b0);
         chk("stall accepted write", 32'({we0, addr0, wd0}), 32'({1'b1, 8'(i), 8'h20 + 8'(i)}));
         rx_valid = 1'b0;
         @(negedge clock);
         chk("stall gap no write", 32'(we0), 32'd0);
      end
      send(8'h86, 1'b0);
      rx_valid = 1'b0;
      chk("stall done", 32'(done0), 32'd1);

      // reset mid-frame drops the pending write
      do_reset();
      send(8'hA5, 1'b0);
      send(8'h04, 1'b0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      reset = 1'b1;
      rx_valid = 1'b0;
      @(negedge clock);
      chk("midreset outputs", 32'({rdy0, we0, addr0, wd0, cr0, done0, err0}),
          32'({1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}));
      s = {8'hA5, 8'h02, 8'h05, 8'h06, 8'h0B};
      run_stream("after midreset", s, 1'b0);
      chk("after midreset done", 32'(done0), 32'd1);

      // LEN=0: 256 bytes, address wraps
      s = {8'hA5, 8'h00};
      for (int i = 0; i < 256; i++) s.push_back(8'(i));
      s.push_back(8'h80);
      run_stream("len256", s, 1'b0);
      chk("len256 done", 32'(done0), 32'd1);
      chk("len256 F0 byte16", (cap1.size() > 16) ? 32'(cap1[16]) : 32'hFFFF_FFFF, 32'h0010);
      chk("len256 last", (cap0.size() == 256) ? 32'(cap0[255]) : 32'hFFFF_FFFF, 32'hFFFF);

      // random streams with gaps
      for (int it = 0; it < 40; it++) begin
         int nf;
         s = {};
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            logic [7:0] gb;
            gb = 8'($urandom_range(0, 255));
            s.push_back((gb == SYNC) ? 8'h00 : gb);
         end
         nf = int'($urandom_range(1, 3));
         for (int f = 0; f < nf; f++) begin
            len = int'($urandom_range(1, 8));
            s.push_back(SYNC);
            s.push_back(8'(len));
            csum = '0;
            for (int j = 0; j < len; j++) begin
               logic [7:0] pb;
               pb = 8'($urandom_range(0, 255));
               s.push_back(pb);
               csum = csum + pb;
            end
            if (f == nf - 1 || $urandom_range(0, 1) == 0) s.push_back(csum);
            else s.push_back(csum ^ 8'($urandom_range(1, 255)));
            if ($urandom_range(0, 1) == 0) s.push_back(8'($urandom_range(0, 255)));
         end
         run_stream($sformatf("rand%0d", it), s, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
